// File: rtl/parity_frame_checker.sv
// Per-frame parity checker: counts beats and rx/calc parity mismatches and
// builds an LRC over a framed byte stream, then emits one status record per frame.
module parity_frame_checker #(
  parameter int DATA_WIDTH    = 8,
  parameter int CNT_WIDTH     = 8,
  parameter int ODD_PARITY    = 0,
  parameter int MAX_FRAME_LEN = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_par_calc,
  input  logic                  in_par_rx,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  out_byte_cnt,
  output logic [CNT_WIDTH-1:0]  out_err_cnt,
  output logic [DATA_WIDTH-1:0] out_lrc,
  output logic                  out_overlen
);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);
  localparam logic                 ODD_BIT = (ODD_PARITY != 0);

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    byte_cnt, byte_cnt_nxt;
  logic [CNT_WIDTH-1:0]    err_cnt, err_cnt_nxt;
  logic [DATA_WIDTH-1:0]   lrc, lrc_nxt;
  logic                    overlen, overlen_nxt;
  logic                    accept;
  logic                    mism;

  assign in_ready = (state != REPORT);
  assign accept   = in_valid & in_ready;
  assign mism     = in_par_rx ^ (in_par_calc ^ ODD_BIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      err_cnt  <= '0;
      lrc      <= '0;
      overlen  <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      err_cnt  <= err_cnt_nxt;
      lrc      <= lrc_nxt;
      overlen  <= overlen_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    err_cnt_nxt  = err_cnt;
    lrc_nxt      = lrc;
    overlen_nxt  = overlen;
    case (state)
      IDLE: begin
        if (accept) begin
          byte_cnt_nxt = ONE_CNT;
          err_cnt_nxt  = CNT_WIDTH'(mism);
          lrc_nxt      = in_data;
          overlen_nxt  = 1'b0;
          if (in_last) begin
            state_nxt = REPORT;
          end else if (MAX_CNT == ONE_CNT) begin
            state_nxt   = REPORT;
            overlen_nxt = 1'b1;
          end else begin
            state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          byte_cnt_nxt = byte_cnt + ONE_CNT;
          // Error count saturates instead of wrapping.
          if (mism && (err_cnt != '1)) begin
            err_cnt_nxt = err_cnt + ONE_CNT;
          end
          lrc_nxt = lrc ^ in_data;
          if (in_last) begin
            state_nxt   = REPORT;
            overlen_nxt = 1'b0;
          end else if (byte_cnt_nxt == MAX_CNT) begin
            state_nxt   = REPORT;
            overlen_nxt = 1'b1;
          end
        end
      end
      REPORT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid    = (state == REPORT);
  assign out_byte_cnt = byte_cnt;
  assign out_err_cnt  = err_cnt;
  assign out_lrc      = lrc;
  assign out_overlen  = overlen;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: dut0 (even, MAX_FRAME_LEN=4) and dut1 (odd, 255),
// table vectors, hand-written corner sequences and a randomized scoreboard run.
module tb_parity_frame_checker;

  typedef struct {
    int       cnt;
    int       err;
    bit [7:0] lrc;
    bit       ovl;
  } rep_t;

  typedef struct {
    int       d;
    bit [7:0] data;
    bit       flip;
    bit       last;
    bit       rep;
    int       cnt;
    int       err;
    bit [7:0] lrc;
    bit       ovl;
  } vec_t;

  logic            clk;
  logic            rst;
  logic [1:0][7:0] in_data;
  logic [1:0]      in_par_calc, in_par_rx, in_last, in_valid, in_ready;
  logic [1:0]      out_valid, out_ready, out_overlen;
  logic [1:0][7:0] out_byte_cnt, out_err_cnt, out_lrc;

  int n_cmp  = 0;
  int n_fail = 0;
  bit use_model;
  bit rnd_ready;
  rep_t q0[$];
  rep_t q1[$];
  int       m_cnt[2];
  int       m_err[2];
  bit [7:0] m_lrc[2];

  parity_frame_checker #(.DATA_WIDTH(8), .CNT_WIDTH(8), .ODD_PARITY(0), .MAX_FRAME_LEN(4)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_par_calc(in_par_calc[0]),
    .in_par_rx(in_par_rx[0]), .in_last(in_last[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_byte_cnt(out_byte_cnt[0]), .out_err_cnt(out_err_cnt[0]),
    .out_lrc(out_lrc[0]), .out_overlen(out_overlen[0]));

  parity_frame_checker #(.DATA_WIDTH(8), .CNT_WIDTH(8), .ODD_PARITY(1), .MAX_FRAME_LEN(255)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_par_calc(in_par_calc[1]),
    .in_par_rx(in_par_rx[1]), .in_last(in_last[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_byte_cnt(out_byte_cnt[1]), .out_err_cnt(out_err_cnt[1]),
    .out_lrc(out_lrc[1]), .out_overlen(out_overlen[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_exp(input int d, input rep_t r);
    if (d == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Frame rules from the data sheet: closes on last or on reaching the length limit.
  task automatic model_beat(input int d, input bit [7:0] data, input bit mism, input bit last);
    int   maxl;
    rep_t r;
    maxl     = (d == 0) ? 4 : 255;
    m_cnt[d] = m_cnt[d] + 1;
    m_err[d] = (m_err[d] + int'(mism) > 255) ? 255 : m_err[d] + int'(mism);
    m_lrc[d] = m_lrc[d] ^ data;
    if (last || m_cnt[d] == maxl) begin
      r = '{cnt: m_cnt[d], err: m_err[d], lrc: m_lrc[d], ovl: !last};
      push_exp(d, r);
      m_cnt[d] = 0;
      m_err[d] = 0;
      m_lrc[d] = '0;
    end
  endtask

  // Called at a negedge; advances one clock and returns at the next negedge.
  task automatic cycle(input int d, output bit acc_d, output bit hs_d);
    bit   acc[2];
    bit   hs[2];
    bit   mism[2];
    rep_t e;
    for (int dd = 0; dd < 2; dd++) begin
      if (rnd_ready) out_ready[dd] = 1'($urandom_range(0, 1));
      acc[dd]  = in_valid[dd] && in_ready[dd];
      hs[dd]   = out_valid[dd] && out_ready[dd];
      mism[dd] = in_par_rx[dd] ^ in_par_calc[dd] ^ (dd == 1);
      if (hs[dd]) begin
        if (qsize(dd) == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_report dut%0d: got cnt=%0d expected no report", dd, out_byte_cnt[dd]);
        end else begin
          e = (dd == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("byte_cnt dut%0d", dd), int'(out_byte_cnt[dd]), e.cnt);
          chk($sformatf("err_cnt dut%0d", dd),  int'(out_err_cnt[dd]), e.err);
          chk($sformatf("lrc dut%0d", dd),      int'(out_lrc[dd]), int'(e.lrc));
          chk($sformatf("overlen dut%0d", dd),  int'(out_overlen[dd]), int'(e.ovl));
        end
      end
    end
    @(posedge clk);
    if (use_model)
      for (int dd = 0; dd < 2; dd++)
        if (acc[dd]) model_beat(dd, in_data[dd], mism[dd], in_last[dd]);
    @(negedge clk);
    acc_d = acc[d];
    hs_d  = hs[d];
  endtask

  task automatic send(input int d, input bit [7:0] data, input bit flip, input bit last);
    bit acc, hs;
    acc            = 1'b0;
    in_data[d]     = data;
    in_par_calc[d] = ^data;
    in_par_rx[d]   = (^data) ^ flip;
    in_last[d]     = last;
    in_valid[d]    = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) cycle(d, acc, hs);
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: got no accept expected accept", d);
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    bit acc, hs;
    rnd_ready    = 1'b0;
    out_ready[d] = 1'b1;
    for (int i = 0; i < 64 && qsize(d) != 0; i++) cycle(d, acc, hs);
    chk($sformatf("drain_pending dut%0d", d), qsize(d), 0);
    out_ready[d] = 1'b0;
  endtask

  initial begin
    vec_t tbl[$];
    bit   acc, hs;
    int   len;
    int   d;

    rst = 1'b0;
    in_data = '0; in_par_calc = '0; in_par_rx = '0; in_last = '0; in_valid = '0;
    out_ready = '0;
    use_model = 1'b0;
    rnd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_err[i] = 0; m_lrc[i] = '0; end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst in_ready dut%0d", i),  int'(in_ready[i]), 1);
      chk($sformatf("rst out_valid dut%0d", i), int'(out_valid[i]), 0);
      chk($sformatf("rst byte_cnt dut%0d", i),  int'(out_byte_cnt[i]), 0);
      chk($sformatf("rst err_cnt dut%0d", i),   int'(out_err_cnt[i]), 0);
      chk($sformatf("rst lrc dut%0d", i),       int'(out_lrc[i]), 0);
      chk($sformatf("rst overlen dut%0d", i),   int'(out_overlen[i]), 0);
    end
    rst = 1'b1;
    @(negedge clk);

    // d, data, flip(rx!=calc), last, report-after-this-beat, cnt, err, lrc, overlen
    tbl.push_back('{0, 8'h01, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 8'h02, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 8'h04, 0, 1, 1, 3, 0, 8'h07, 0});
    tbl.push_back('{0, 8'h01, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 8'h02, 1, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 8'h04, 0, 1, 1, 3, 1, 8'h07, 0});
    tbl.push_back('{1, 8'h01, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{1, 8'h02, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{1, 8'h04, 0, 1, 1, 3, 3, 8'h07, 0});
    tbl.push_back('{1, 8'h01, 1, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{1, 8'h02, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{1, 8'h04, 1, 1, 1, 3, 1, 8'h07, 0});
    tbl.push_back('{0, 8'h11, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 8'h22, 1, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 8'h44, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 8'h88, 0, 0, 1, 4, 1, 8'hFF, 1});
    tbl.push_back('{0, 8'h0F, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 8'h01, 0, 1, 1, 2, 0, 8'h0E, 0});
    tbl.push_back('{0, 8'h01, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 8'h02, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 8'h03, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 8'h04, 0, 1, 1, 4, 0, 8'h04, 0});
    out_ready = 2'b11;
    foreach (tbl[i]) begin
      if (tbl[i].rep)
        push_exp(tbl[i].d, '{cnt: tbl[i].cnt, err: tbl[i].err, lrc: tbl[i].lrc, ovl: tbl[i].ovl});
      send(tbl[i].d, tbl[i].data, tbl[i].flip, tbl[i].last);
    end
    drain(0);
    drain(1);

    // Single-beat frame: in_ready low until the handshake, high the cycle after.
    push_exp(0, '{cnt: 1, err: 0, lrc: 8'hA5, ovl: 1'b0});
    send(0, 8'hA5, 0, 1);
    chk("single in_ready", int'(in_ready[0]), 0);
    chk("single out_valid", int'(out_valid[0]), 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, acc, hs);
      chk("single hold in_ready", int'(in_ready[0]), 0);
    end
    out_ready[0] = 1'b1;
    cycle(0, acc, hs);
    chk("single handshake", int'(hs), 1);
    out_ready[0] = 1'b0;
    chk("single post in_ready", int'(in_ready[0]), 1);
    chk("single post out_valid", int'(out_valid[0]), 0);

    // Back-pressure with a beat waiting at the input.
    push_exp(0, '{cnt: 1, err: 1, lrc: 8'h5A, ovl: 1'b0});
    send(0, 8'h5A, 1, 1);
    in_data[0] = 8'h77; in_par_calc[0] = ^8'h77; in_par_rx[0] = ^8'h77;
    in_last[0] = 1'b1;  in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, acc, hs);
      chk("bp no accept", int'(acc), 0);
      chk("bp out_valid", int'(out_valid[0]), 1);
      chk("bp lrc stable", int'(out_lrc[0]), 8'h5A);
      chk("bp err stable", int'(out_err_cnt[0]), 1);
    end
    push_exp(0, '{cnt: 1, err: 0, lrc: 8'h77, ovl: 1'b0});
    out_ready[0] = 1'b1;
    cycle(0, acc, hs);
    chk("bp release handshake", int'(hs), 1);
    chk("bp release no accept", int'(acc), 0);
    out_ready[0] = 1'b0;
    cycle(0, acc, hs);
    chk("bp next accept", int'(acc), 1);
    chk("bp single handshake", int'(hs), 0);
    in_valid[0] = 1'b0;
    drain(0);

    // Asynchronous reset mid-frame discards the partial frame.
    send(0, 8'h11, 1, 0);
    send(0, 8'h22, 0, 0);
    #3 rst = 1'b0;
    #1;
    chk("midrst out_valid", int'(out_valid[0]), 0);
    chk("midrst in_ready", int'(in_ready[0]), 1);
    chk("midrst byte_cnt", int'(out_byte_cnt[0]), 0);
    chk("midrst lrc", int'(out_lrc[0]), 0);
    @(negedge clk);
    rst = 1'b1;
    push_exp(0, '{cnt: 1, err: 0, lrc: 8'h3C, ovl: 1'b0});
    send(0, 8'h3C, 0, 1);
    drain(0);

    // Randomized frames against the scoreboard model, random output back-pressure.
    use_model = 1'b1;
    for (int f = 0; f < 160; f++) begin
      d         = f % 2;
      len       = (d == 0) ? $urandom_range(1, 9) : $urandom_range(1, 12);
      rnd_ready = 1'b1;
      for (int k = 0; k < len; k++)
        send(d, 8'($urandom), 1'($urandom_range(0, 3) == 0), k == len - 1);
    end
    drain(0);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
